// File: rtl/line_pkg.sv
// Shared types and constants for the line_extractor block: coordinate widths,
// FSM states, result record and the default key colour.
package line_pkg;

    localparam int XW = 11;
    localparam int YW = 10;

    localparam logic [7:0] KEY_R_DEF = 8'd222;
    localparam logic [7:0] KEY_G_DEF = 8'd222;
    localparam logic [7:0] KEY_B_DEF = 8'd0;

    // Row counter saturates instead of wrapping.
    localparam logic [YW-1:0] ROW_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARMED, SCAN, REPORT} lx_state_t;

    typedef struct packed {
        logic [XW-1:0] x_start;
        logic [XW-1:0] x_end;
        logic [YW-1:0] y_start;
        logic [YW-1:0] y_end;
        logic [YW-1:0] row_count;
        logic          found;
    } lx_result_t;

endpackage

// File: rtl/line_extractor_if.sv
// Raster/colour stream plus start/done result bundle for line_extractor.
// The mono result only exists when LINEEXT_MONO_EN is defined.
interface line_extractor_if;
    import line_pkg::*;

    logic          start;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          x_period;
    logic          y_period;
    logic [7:0]    red;
    logic [7:0]    green;
    logic [7:0]    blue;

    logic          busy;
    logic          done;
    logic          found;
    logic [XW-1:0] x_start;
    logic [XW-1:0] x_end;
    logic [YW-1:0] y_start;
    logic [YW-1:0] y_end;
    logic [YW-1:0] row_count;
`ifdef LINEEXT_MONO_EN
    logic          mono;

    modport master (output start, x_cnt, y_cnt, x_period, y_period, red, green, blue,
                    input  busy, done, found, x_start, x_end, y_start, y_end, row_count, mono);
    modport slave  (input  start, x_cnt, y_cnt, x_period, y_period, red, green, blue,
                    output busy, done, found, x_start, x_end, y_start, y_end, row_count, mono);
`else
    modport master (output start, x_cnt, y_cnt, x_period, y_period, red, green, blue,
                    input  busy, done, found, x_start, x_end, y_start, y_end, row_count);
    modport slave  (input  start, x_cnt, y_cnt, x_period, y_period, red, green, blue,
                    output busy, done, found, x_start, x_end, y_start, y_end, row_count);
`endif

endinterface

// File: rtl/line_extractor_pix_delay.sv
// pix_delay: fixed-depth shift register aligning raster counts with pixel colour.
// Latency DEPTH cycles (DEPTH=0 is a wire); no backpressure, advances every cycle.
module pix_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] sr [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= din;
                    for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/line_extractor.sv
// line_extractor: captures one full frame and reports first/last key-colour row edges.
// Latency: done PIX_LAT+1 cycles after raw counts hit frame end; no backpressure (start while busy is dropped).
// Build option LINEEXT_MONO_EN adds the mono (edges non-decreasing) result.
module line_extractor
    import line_pkg::*;
#(
    parameter int         H_TOTAL = 1056,
    parameter int         V_TOTAL = 525,
    parameter int         PIX_LAT = 2,
    parameter logic [7:0] KEY_R   = KEY_R_DEF,
    parameter logic [7:0] KEY_G   = KEY_G_DEF,
    parameter logic [7:0] KEY_B   = KEY_B_DEF
) (
    input  logic             clk,
    input  logic             reset,
    line_extractor_if.slave  bus
);

    localparam int            DW     = XW + YW + 2;
    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    logic [DW-1:0] d_in, d_out;
    logic [XW-1:0] dx;
    logic [YW-1:0] dy;
    logic          dx_period, dy_period;

    assign d_in = {bus.x_cnt, bus.y_cnt, bus.x_period, bus.y_period};

    pix_delay #(.WIDTH(DW), .DEPTH(PIX_LAT)) u_pix_delay (
        .clk   (clk),
        .reset (reset),
        .din   (d_in),
        .dout  (d_out)
    );

    assign {dx, dy, dx_period, dy_period} = d_out;

    logic dact, match, frame_first, frame_last;

    assign dact        = dx_period & dy_period;
    assign match       = dact & (bus.red == KEY_R) & (bus.green == KEY_G) & (bus.blue == KEY_B);
    assign frame_first = (dx == '0) && (dy == '0);
    assign frame_last  = (dx == X_LAST) && (dy == Y_LAST);

    lx_state_t  state, state_nxt;
    lx_result_t scr, scr_nxt, res;
    logic       row_hit, row_hit_nxt;
    logic       capture;
`ifdef LINEEXT_MONO_EN
    logic          mono_scr, mono_scr_nxt, mono_res;
    logic [XW-1:0] prev_edge, prev_edge_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        scr_nxt     = scr;
        row_hit_nxt = row_hit;
        capture     = 1'b0;
`ifdef LINEEXT_MONO_EN
        mono_scr_nxt  = mono_scr;
        prev_edge_nxt = prev_edge;
`endif
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = ARMED;
            end
            ARMED: begin
                // The (0,0) pixel itself belongs to the frame, so it is scanned on this cycle too.
                if (frame_first) begin
                    state_nxt   = SCAN;
                    scr_nxt     = '0;
                    row_hit_nxt = 1'b0;
                    capture     = 1'b1;
`ifdef LINEEXT_MONO_EN
                    mono_scr_nxt = 1'b1;
`endif
                end
            end
            SCAN: begin
                capture = 1'b1;
                if (frame_last) state_nxt = REPORT;
            end
            REPORT: begin
                state_nxt = IDLE;
            end
        endcase

        if (capture) begin
            if (dx == '0) row_hit_nxt = 1'b0;
            if (match && !row_hit_nxt) begin
                row_hit_nxt = 1'b1;
`ifdef LINEEXT_MONO_EN
                if ((scr_nxt.row_count != '0) && (dx < prev_edge)) mono_scr_nxt = 1'b0;
                prev_edge_nxt = dx;
`endif
                if (scr_nxt.row_count == '0) begin
                    scr_nxt.x_start = dx;
                    scr_nxt.y_start = dy;
                end
                scr_nxt.x_end = dx;
                scr_nxt.y_end = dy;
                scr_nxt.found = 1'b1;
                if (scr_nxt.row_count != ROW_MAX) scr_nxt.row_count = scr_nxt.row_count + YW'(1);
            end
        end
    end

    // Results are published on entry to REPORT so they are valid alongside done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            scr     <= '0;
            row_hit <= 1'b0;
            res     <= '0;
`ifdef LINEEXT_MONO_EN
            mono_scr  <= 1'b0;
            prev_edge <= '0;
            mono_res  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            scr     <= scr_nxt;
            row_hit <= row_hit_nxt;
            if (state == SCAN && frame_last) res <= scr_nxt;
`ifdef LINEEXT_MONO_EN
            mono_scr  <= mono_scr_nxt;
            prev_edge <= prev_edge_nxt;
            if (state == SCAN && frame_last) mono_res <= mono_scr_nxt;
`endif
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == REPORT);
    assign bus.found     = res.found;
    assign bus.x_start   = res.x_start;
    assign bus.x_end     = res.x_end;
    assign bus.y_start   = res.y_start;
    assign bus.y_end     = res.y_end;
    assign bus.row_count = res.row_count;
`ifdef LINEEXT_MONO_EN
    assign bus.mono      = mono_res;
`endif

endmodule
